// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single ROB writeback port among NUM_REQ execution units.
//   Each requester owns a 1-entry holding register with a valid/ready
//   handshake. A round-robin arbiter drains one held result per cycle onto
//   the registered common data bus (CDB), which feeds ROB writeback and
//   RS/LSB wakeup. A mispredict flush empties every holding register.
//
//   Optional build macro: CDB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins (no rotating pointer)
//     undefined -> round-robin starting from rr_ptr
//
// Ports
//   clk_in      system clock
//   rst_in      synchronous active-low reset
//   rdy_in      global ready; the block is frozen while low
//   flush_in    ROB clear pulse; drops all pending results
//   req_valid   per-requester result valid
//   req_ready   per-requester accept (combinational)
//   req_rob_id  flattened ROB ids, requester i at [i*ROB_W +: ROB_W]
//   req_value   flattened values, requester i at [i*VAL_W +: VAL_W]
//   cdb_valid   registered CDB valid (one-cycle pulse per result)
//   cdb_rob_id  registered ROB index
//   cdb_value   registered result value
//   cdb_src     registered index of the granted requester
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter  int NUM_REQ = 3,
    parameter  int ROB_W   = 4,
    parameter  int VAL_W   = 32,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ROB_W-1:0]   req_rob_id,
    input  logic [NUM_REQ*VAL_W-1:0]   req_value,
    output logic                       cdb_valid,
    output logic [ROB_W-1:0]           cdb_rob_id,
    output logic [VAL_W-1:0]           cdb_value,
    output logic [SRC_W-1:0]           cdb_src
);

    // (base + k) mod NUM_REQ; base < NUM_REQ and k <= NUM_REQ so one wrap suffices
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[SRC_W-1:0];
    endfunction

    logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
    logic [ROB_W-1:0]   hold_rob_id_q [NUM_REQ];
    logic [ROB_W-1:0]   hold_rob_id_d [NUM_REQ];
    logic [VAL_W-1:0]   hold_value_q  [NUM_REQ];
    logic [VAL_W-1:0]   hold_value_d  [NUM_REQ];

    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]   cdb_rob_id_q, cdb_rob_id_d;
    logic [VAL_W-1:0]   cdb_value_q, cdb_value_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic [SRC_W-1:0]   rr_ptr_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_any_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic [SRC_W-1:0]   scan_idx_s;

`ifdef CDB_FIXED_PRIO_EN
    // Fixed priority: scan always starts at requester 0
    assign rr_ptr_s = {SRC_W{1'b0}};
`else
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_s = rr_ptr_q;

    // Round-robin pointer: moves past the winner, returns to 0 on flush
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rdy_in && flush_in) begin
            rr_ptr_d = {SRC_W{1'b0}};
        end else if (rdy_in && grant_any_s) begin
            rr_ptr_d = wrap_add(grant_idx_s, 1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rr_ptr_q <= {SRC_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Grant: first occupied hold scanning upward from rr_ptr with wrap
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        grant_any_s = 1'b0;
        grant_idx_s = {SRC_W{1'b0}};
        scan_idx_s  = {SRC_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = wrap_add(rr_ptr_s, k);
            if (!grant_any_s && hold_valid_q[scan_idx_s]) begin
                grant_any_s         = 1'b1;
                grant_s[scan_idx_s] = 1'b1;
                grant_idx_s         = scan_idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // A hold being drained this cycle may be refilled in the same cycle;
    // reset also closes the door so nothing is accepted while held in reset.
    assign req_ready = {NUM_REQ{rst_in & rdy_in & ~flush_in}} & (~hold_valid_q | grant_s);

    // Next-state for holds and CDB; flush beats drain and accept
    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_rob_id_d = hold_rob_id_q;
        hold_value_d  = hold_value_q;
        cdb_valid_d   = cdb_valid_q;
        cdb_rob_id_d  = cdb_rob_id_q;
        cdb_value_d   = cdb_value_q;
        cdb_src_d     = cdb_src_q;
        if (rdy_in && flush_in) begin
            hold_valid_d = {NUM_REQ{1'b0}};
            cdb_valid_d  = 1'b0;
        end else if (rdy_in) begin
            if (grant_any_s) begin
                cdb_valid_d                 = 1'b1;
                cdb_rob_id_d                = hold_rob_id_q[grant_idx_s];
                cdb_value_d                 = hold_value_q[grant_idx_s];
                cdb_src_d                   = grant_idx_s;
                hold_valid_d[grant_idx_s]   = 1'b0;
            end else begin
                cdb_valid_d = 1'b0;
            end
            // accept after drain so a same-cycle refill keeps the hold full
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold_valid_d[i]  = 1'b1;
                    hold_rob_id_d[i] = req_rob_id[i*ROB_W +: ROB_W];
                    hold_value_d[i]  = req_value[i*VAL_W +: VAL_W];
                end else begin
                    hold_valid_d[i]  = hold_valid_d[i];
                end
            end
        end else begin
            cdb_valid_d = cdb_valid_q;
        end
    end

    // Hold and CDB registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hold_valid_q <= {NUM_REQ{1'b0}};
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_rob_id_q[i] <= {ROB_W{1'b0}};
                hold_value_q[i]  <= {VAL_W{1'b0}};
            end
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= {ROB_W{1'b0}};
            cdb_value_q  <= {VAL_W{1'b0}};
            cdb_src_q    <= {SRC_W{1'b0}};
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_rob_id_q <= hold_rob_id_d;
            hold_value_q  <= hold_value_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_id_q  <= cdb_rob_id_d;
            cdb_value_q   <= cdb_value_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;

endmodule
